// File: rtl/scoreboard_scan_ctrl_if.sv
// Bundle of score, handshake and display-scan signals for scoreboard_scan_ctrl.
// master drives score_in/update_req; slave is the scan controller.
interface scoreboard_scan_ctrl_if;
  logic [7:0] score_in;
  logic       update_req;
  logic       update_ack;
  logic [7:0] score_out;
  logic       sel;
  logic [1:0] an;
  logic       frame_start;

  modport master (
    output score_in, update_req,
    input  update_ack, score_out, sel, an, frame_start
  );

  modport slave (
    input  score_in, update_req,
    output update_ack, score_out, sel, an, frame_start
  );
endinterface

// File: rtl/scoreboard_scan_ctrl.sv
// Two-digit BCD display scanner with blanking gaps and frame-aligned score latching.
// Optional: define LEADING_ZERO_BLANK_EN to keep a zero tens digit dark.
module scoreboard_scan_ctrl #(
  parameter int unsigned TICK_DIV         = 50000,
  parameter int unsigned SHOW_TICKS       = 4,
  parameter int unsigned BLANK_TICKS      = 1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  scoreboard_scan_ctrl_if.slave bus
);
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAXT = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int unsigned CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [1:0]    AN_OFF     = ANODE_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre;
  logic          tick;
  logic [CW-1:0] phase, phase_nxt;
  logic          digit, digit_nxt;
  logic          pending;
  logic          boundary;
  logic          take;
  logic [1:0]    an_on;

  always_comb begin
    tick      = (pre == PRE_LAST);
    state_nxt = state;
    phase_nxt = phase;
    digit_nxt = digit;
    boundary  = 1'b0;
    if (tick) begin
      unique case (state)
        BLANK: begin
          if (phase == BLANK_LAST) begin
            state_nxt = SHOW;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + CW'(1);
          end
        end
        SHOW: begin
          if (phase == SHOW_LAST) begin
            state_nxt = BLANK;
            phase_nxt = '0;
            digit_nxt = ~digit;
            boundary  = digit;
          end else begin
            phase_nxt = phase + CW'(1);
          end
        end
      endcase
    end

    // Anodes are registered from next state so they switch on the same edge as sel.
    an_on = '0;
    if (state_nxt == SHOW) an_on = digit_nxt ? 2'b10 : 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
    if (digit_nxt && (bus.score_out[7:4] == 4'h0)) an_on = '0;
`endif

    take = boundary & (pending | bus.update_req);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre             <= '0;
      state           <= BLANK;
      phase           <= '0;
      digit           <= 1'b0;
      pending         <= 1'b0;
      bus.sel         <= 1'b0;
      bus.an          <= AN_OFF;
      bus.score_out   <= '0;
      bus.update_ack  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      pre             <= tick ? '0 : pre + PW'(1);
      state           <= state_nxt;
      phase           <= phase_nxt;
      digit           <= digit_nxt;
      bus.sel         <= digit_nxt;
      bus.an          <= an_on ^ AN_OFF;
      bus.frame_start <= boundary;
      bus.update_ack  <= take;
      pending         <= boundary ? 1'b0 : (pending | bus.update_req);
      if (take) bus.score_out <= bus.score_in;
    end
  end
endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Bench for scoreboard_scan_ctrl: scan table, handshake corner cases, random run vs slot-arithmetic model.
module tb_scoreboard_scan_ctrl;
  localparam int D = 4;
  localparam int S = 2;
  localparam int B = 1;
  localparam int L = (S + B) * D;
  localparam int P = 2 * L;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scoreboard_scan_ctrl_if bus ();

  scoreboard_scan_ctrl #(
    .TICK_DIV(D), .SHOW_TICKS(S), .BLANK_TICKS(B), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: cycle index since reset plus the latch/pending rules.
  int         c;
  logic       m_pend;
  logic [7:0] m_score;
  logic       m_ack;
  logic       m_fs;
  int         ack_count;

  typedef struct {
    int         n;
    logic [1:0] an;
    logic       sel;
  } scan_row_t;
  scan_row_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, c, got, want);
    end
  endtask

  function automatic logic [1:0] exp_an(input int cc, input logic [7:0] sc);
    int p, d, q;
    logic [1:0] on;
    p = (cc - 1) % P;
    d = p / L;
    q = p % L;
    on = 2'b00;
    if (q >= B * D) on = (d == 1) ? 2'b10 : 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 1 && sc[7:4] == 4'h0) on = 2'b00;
`endif
    return ~on;
  endfunction

  function automatic logic exp_sel(input int cc);
    return (((cc - 1) % P) / L) == 1;
  endfunction

  task automatic cycle(input logic r, input logic q, input logic [7:0] s);
    logic [12:0] got, want;
    reset          = r;
    bus.update_req = q;
    bus.score_in   = s;
    @(posedge clk);
    if (r) begin
      c = 1; m_pend = 1'b0; m_score = 8'h00; m_ack = 1'b0; m_fs = 1'b0;
    end else begin
      c++;
      m_fs = ((c - 1) % P) == 0;
      if (m_fs) begin
        m_ack = m_pend | q;
        if (m_ack) m_score = s;
        m_pend = 1'b0;
      end else begin
        m_ack  = 1'b0;
        m_pend = m_pend | q;
      end
    end
    @(negedge clk);
    if (bus.update_ack === 1'b1) ack_count++;
    got  = {bus.an, bus.sel, bus.frame_start, bus.update_ack, bus.score_out};
    want = {exp_an(c, m_score), exp_sel(c), m_fs, m_ack, m_score};
    chk("cyc{an,sel,fs,ack,score}", 32'(got), 32'(want));
  endtask

  // Any sel change must happen with both anodes dark.
  logic prev_sel;
  always @(negedge clk) begin
    if (!$isunknown(prev_sel) && !$isunknown(bus.sel) && bus.sel !== prev_sel)
      chk("ghost_an_at_sel_change", 32'(bus.an), 32'(2'b11));
    prev_sel = bus.sel;
  end

  task automatic run_to_before_boundary(input logic [7:0] s);
    // Stop when the next edge is a frame boundary.
    for (int i = 0; i < P + 1; i++) begin
      if ((c % P) == 0) break;
      cycle(1'b0, 1'b0, s);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.update_req = 1'b0;
    bus.score_in = 8'h00;
    prev_sel = 1'bx;
    ack_count = 0;
    c = 0;

    tbl[0] = '{4, 2'b11, 1'b0};
    tbl[1] = '{8, 2'b10, 1'b0};
    tbl[2] = '{4, 2'b11, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[3] = '{8, 2'b11, 1'b1};
`else
    tbl[3] = '{8, 2'b01, 1'b1};
`endif
    tbl[4] = '{4, 2'b11, 1'b0};
    tbl[5] = '{8, 2'b10, 1'b0};

    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    begin
      bit first;
      first = 1'b1;
      for (int r = 0; r < 6; r++) begin
        for (int j = 0; j < tbl[r].n; j++) begin
          if (!first) cycle(1'b0, 1'b0, 8'h00);
          first = 1'b0;
          chk("scan_tbl_an", 32'(bus.an), 32'(tbl[r].an));
          chk("scan_tbl_sel", 32'(bus.sel), 32'(tbl[r].sel));
          if (c == 25) chk("scan_tbl_frame_start", 32'(bus.frame_start), 32'd1);
        end
      end
    end

    // Mid-frame request: latched value is score_in at the boundary.
    cycle(1'b0, 1'b1, 8'h57);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h57);
    chk("hs_hold_before_boundary", 32'(bus.score_out), 32'h00);
    run_to_before_boundary(8'h57);
    cycle(1'b0, 1'b0, 8'h57);
    chk("hs_latch_57", 32'(bus.score_out), 32'h57);
    chk("hs_ack_57", 32'(bus.update_ack), 32'd1);
    chk("hs_fs_57", 32'(bus.frame_start), 32'd1);
    cycle(1'b0, 1'b0, 8'h57);
    chk("hs_ack_one_cycle", 32'(bus.update_ack), 32'd0);

    cycle(1'b0, 1'b1, 8'h57);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h57);
    run_to_before_boundary(8'h99);
    cycle(1'b0, 1'b0, 8'h99);
    chk("hs_latch_99", 32'(bus.score_out), 32'h99);

    // Request on the boundary cycle itself.
    run_to_before_boundary(8'h33);
    cycle(1'b0, 1'b1, 8'h12);
    chk("coincide_latch_12", 32'(bus.score_out), 32'h12);
    chk("coincide_ack", 32'(bus.update_ack), 32'd1);

    // Three requests in one frame yield one ack.
    ack_count = 0;
    for (int i = 0; i < 20; i++) cycle(1'b0, (i == 2 || i == 8 || i == 15), 8'h21);
    run_to_before_boundary(8'h21);
    for (int i = 0; i < P + 2; i++) cycle(1'b0, 1'b0, 8'h21);
    chk("multi_req_one_ack", 32'(ack_count), 32'd1);
    chk("multi_req_score", 32'(bus.score_out), 32'h21);

    // Reset mid units SHOW with a pending request.
    for (int i = 0; i < P + 1; i++) begin
      if (((c - 1) % P) == 8) break;
      cycle(1'b0, 1'b0, 8'h34);
    end
    cycle(1'b0, 1'b1, 8'h34);
    cycle(1'b1, 1'b0, 8'h34);
    chk("rst_an_off", 32'(bus.an), 32'(2'b11));
    chk("rst_score_zero", 32'(bus.score_out), 32'h00);
    chk("rst_no_ack", 32'(bus.update_ack), 32'd0);
    ack_count = 0;
    for (int i = 0; i < P + 2; i++) cycle(1'b0, 1'b0, 8'h34);
    chk("rst_pending_lost", 32'(ack_count), 32'd0);

    // Leading-zero scores: 07 and 10 through full frames.
    run_to_before_boundary(8'h07);
    cycle(1'b0, 1'b1, 8'h07);
    for (int i = 0; i < P; i++) cycle(1'b0, 1'b0, 8'h07);
    run_to_before_boundary(8'h10);
    cycle(1'b0, 1'b1, 8'h10);
    for (int i = 0; i < P; i++) cycle(1'b0, 1'b0, 8'h10);

    // Random traffic including occasional resets and non-BCD nibbles.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(299) == 0), ($urandom_range(7) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
